// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with configurable-depth input and output FIFOs between a processor
// memory-mapped port and a Cardinal ring router; exposes occupancy and a sticky overflow flag.
module cardinal_nic_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int IN_DEPTH   = 4,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  net_si,
   input  logic [DATA_WIDTH-1:0] net_di,
   output logic                  net_ri,
   input  logic                  net_ro,
   input  logic                  net_polarity,
   output logic                  net_so,
   output logic [DATA_WIDTH-1:0] net_do
);

   localparam int ICW = $clog2(IN_DEPTH + 1);
   localparam int OCW = $clog2(OUT_DEPTH + 1);
   localparam int IPW = $clog2(IN_DEPTH);
   localparam int OPW = $clog2(OUT_DEPTH);

   localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
   localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);

   localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   // ---------------------------------------------------------------- storage
   logic [DATA_WIDTH-1:0] in_mem  [IN_DEPTH];
   logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];

   logic [IPW-1:0] in_wr_ptr, in_rd_ptr;
   logic [ICW-1:0] in_count;
   logic [OPW-1:0] out_wr_ptr, out_rd_ptr;
   logic [OCW-1:0] out_count;
   logic           ovf;

   // ---------------------------------------------------------------- access decode
   logic rd_en, wr_en;
   logic in_empty, in_full, in_push, in_pop;
   logic out_empty, out_full, out_wr, out_push, out_send, ovf_set, ovf_clr;
   logic [DATA_WIDTH-1:0] in_head, out_head;

   assign rd_en = nicEn & ~nicWrEn;
   assign wr_en = nicEn & nicWrEn;

   assign in_empty = (in_count == '0);
   assign in_full  = (in_count == IN_FULL);
   assign net_ri   = ~in_full;
   assign in_push  = net_si & ~in_full;
   assign in_pop   = rd_en & (addr == ADDR_IN_DATA) & ~in_empty;
   assign in_head  = in_mem[in_rd_ptr];

   // Full is judged on pre-edge state, so a write at full is rejected even if a send frees a slot.
   assign out_empty = (out_count == '0);
   assign out_full  = (out_count == OUT_FULL);
   assign out_wr    = wr_en & (addr == ADDR_OUT_DATA);
   assign out_push  = out_wr & ~out_full;
   assign ovf_set   = out_wr & out_full;
   assign ovf_clr   = rd_en & (addr == ADDR_OUT_STAT);
   assign out_head  = out_mem[out_rd_ptr];
   assign out_send  = ~out_empty & net_ro & (net_polarity == out_head[DATA_WIDTH-1]);

   // ---------------------------------------------------------------- read mux
   logic [DATA_WIDTH-1:0] in_status, out_status, read_data;

   always_comb begin
      in_status                 = '0;
      in_status[DATA_WIDTH-1]   = ~in_empty;
      in_status[ICW-1:0]        = in_count;

      out_status                = '0;
      out_status[DATA_WIDTH-1]  = out_full;
      out_status[DATA_WIDTH-2]  = ovf;
      out_status[OCW-1:0]       = out_count;

      read_data = '0;
      unique case (addr)
         ADDR_IN_DATA:  read_data = in_empty ? '0 : in_head;
         ADDR_IN_STAT:  read_data = in_status;
         ADDR_OUT_DATA: read_data = '0;
         ADDR_OUT_STAT: read_data = out_status;
         default:       read_data = '0;
      endcase
   end

   // ---------------------------------------------------------------- FIFO data arrays
   // NOTE: storage has no reset; only pointers and counts define which entries are valid.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wr_ptr]   <= net_di;
      if (out_push) out_mem[out_wr_ptr] <= d_in;
   end

   // ---------------------------------------------------------------- input FIFO control
   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_wr_ptr <= '0;
         in_rd_ptr <= '0;
         in_count  <= '0;
      end else begin
         if (in_push) in_wr_ptr <= in_wr_ptr + IPW'(1);
         if (in_pop)  in_rd_ptr <= in_rd_ptr + IPW'(1);
         unique case ({in_push, in_pop})
            2'b10:   in_count <= in_count + ICW'(1);
            2'b01:   in_count <= in_count - ICW'(1);
            default: in_count <= in_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- output FIFO control
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_count  <= '0;
      end else begin
         if (out_push) out_wr_ptr <= out_wr_ptr + OPW'(1);
         if (out_send) out_rd_ptr <= out_rd_ptr + OPW'(1);
         unique case ({out_push, out_send})
            2'b10:   out_count <= out_count + OCW'(1);
            2'b01:   out_count <= out_count - OCW'(1);
            default: out_count <= out_count;
         endcase
      end
   end

   // Set wins over clear; single-ported access keeps them on separate cycles anyway.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   // ---------------------------------------------------------------- registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     d_out <= '0;
      else if (rd_en) d_out <= read_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         net_so <= 1'b0;
         net_do <= '0;
      end else begin
         net_so <= out_send;
         if (out_send) net_do <= out_head;
      end
   end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Self-checking bench for cardinal_nic_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_cardinal_nic_fifo;

   localparam int DW = 64;
   localparam int ID = 4;
   localparam int OD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    addr;
   logic [DW-1:0] d_in;
   logic          nicEn, nicWrEn;
   logic [DW-1:0] d_out;
   logic          net_si;
   logic [DW-1:0] net_di;
   logic          net_ri;
   logic          net_ro, net_polarity;
   logic          net_so;
   logic [DW-1:0] net_do;

   int errors = 0;
   int checks = 0;

   cardinal_nic_fifo #(.DATA_WIDTH(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn), .nicWrEn(nicWrEn),
      .d_out(d_out), .net_si(net_si), .net_di(net_di), .net_ri(net_ri), .net_ro(net_ro),
      .net_polarity(net_polarity), .net_so(net_so), .net_do(net_do)
   );

   initial forever #5 clk = ~clk;

   // ---------------------------------------------------------------- reference model
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] out_q[$];
   bit            m_ovf;
   logic [DW-1:0] m_dout, m_do;
   bit            m_so;

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      in_q.delete();
      out_q.delete();
      m_ovf  = 0;
      m_dout = '0;
      m_do   = '0;
      m_so   = 0;
   endtask

   task automatic model_edge();
      bit rd, wr, pop_in, push_in, push_out, send, set_ovf;
      logic [DW-1:0] st;
      if (!reset) begin
         model_reset();
         return;
      end
      rd       = nicEn && !nicWrEn;
      wr       = nicEn && nicWrEn;
      pop_in   = rd && addr == 2'd0 && in_q.size() != 0;
      push_in  = net_si && in_q.size() < ID;
      push_out = wr && addr == 2'd2 && out_q.size() < OD;
      set_ovf  = wr && addr == 2'd2 && out_q.size() == OD;
      send     = out_q.size() != 0 && net_ro && net_polarity == out_q[0][DW-1];
      if (rd) begin
         st = '0;
         case (addr)
            2'd0: st = pop_in ? in_q[0] : '0;
            2'd1: begin
               st = DW'(in_q.size());
               st[DW-1] = (in_q.size() != 0);
            end
            2'd2: st = '0;
            default: begin
               st = DW'(out_q.size());
               st[DW-1] = (out_q.size() == OD);
               st[DW-2] = m_ovf;
            end
         endcase
         m_dout = st;
      end
      if (set_ovf) m_ovf = 1;
      else if (rd && addr == 2'd3) m_ovf = 0;
      m_so = send;
      if (send) m_do = out_q[0];
      if (pop_in)   void'(in_q.pop_front());
      if (push_in)  in_q.push_back(net_di);
      if (send)     void'(out_q.pop_front());
      if (push_out) out_q.push_back(d_in);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
      net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      idle();
      reset = 1;
      net_ro = 1; net_polarity = 0;
      for (int i = 0; i < 3; i++) begin
         net_si = 1; net_di = rnd64();
         nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = {1'b0, rnd64() >> 1} | 64'h10;
         step();
      end
      nicWrEn = 0; addr = 2'd0;
      step();
      #2 reset = 0;
      model_reset();
      #1;
      checks++; if (d_out !== '0)  begin errors++; $display("FAIL reset_d_out: got %h want 0", d_out); end
      checks++; if (net_so !== 0)  begin errors++; $display("FAIL reset_net_so: got %b want 0", net_so); end
      checks++; if (net_do !== '0) begin errors++; $display("FAIL reset_net_do: got %h want 0", net_do); end
      checks++; if (net_ri !== 1)  begin errors++; $display("FAIL reset_net_ri: got %b want 1", net_ri); end
      idle();
      step(); step();
      reset = 1;
      step();
      checks++; if (net_so !== 0) begin errors++; $display("FAIL reset_first_idle_so: got %b want 0", net_so); end
      nicEn = 1; addr = 2'd1; step();
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_in_status: got %h want 0", d_out); end
      addr = 2'd3; step();
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_out_status: got %h want 0", d_out); end
      idle();
   endtask

   task automatic test_in_fill();
      logic [DW-1:0] pkt[4];
      idle();
      for (int i = 0; i < 4; i++) begin
         pkt[i] = rnd64();
         net_si = 1; net_di = pkt[i];
         step();
      end
      net_si = 0;
      checks++; if (net_ri !== 0) begin errors++; $display("FAIL fill_net_ri_low: got %b want 0", net_ri); end
      nicEn = 1; nicWrEn = 0; addr = 2'd1; step();
      checks++; if (d_out !== 64'h8000_0000_0000_0004) begin errors++; $display("FAIL fill_status: got %h want 8000000000000004", d_out); end
      addr = 2'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (d_out !== pkt[i]) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, d_out, pkt[i]); end
         if (i == 0) begin
            checks++; if (net_ri !== 1) begin errors++; $display("FAIL drain_net_ri_high: got %b want 1", net_ri); end
         end
      end
      step();
      checks++; if (d_out !== '0) begin errors++; $display("FAIL empty_read: got %h want 0", d_out); end
      idle();
   endtask

   task automatic test_out_overflow();
      logic [DW-1:0] w[5];
      idle();
      for (int i = 0; i < 5; i++) begin
         w[i] = rnd64(); w[i][DW-1] = 1'b0;
         nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = w[i];
         step();
      end
      nicWrEn = 0; addr = 2'd3; step();
      checks++; if (d_out !== 64'hC000_0000_0000_0004) begin errors++; $display("FAIL ovf_status: got %h want c000000000000004", d_out); end
      step();
      checks++; if (d_out !== 64'h8000_0000_0000_0004) begin errors++; $display("FAIL ovf_cleared: got %h want 8000000000000004", d_out); end
      nicEn = 0; net_ro = 1; net_polarity = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i < 4) begin
            checks++; if (net_so !== 1 || net_do !== w[i]) begin errors++; $display("FAIL ovf_send[%0d]: got so=%b do=%h want so=1 do=%h", i, net_so, net_do, w[i]); end
         end else begin
            checks++; if (net_so !== 0 || net_do !== w[3]) begin errors++; $display("FAIL ovf_no_fifth[%0d]: got so=%b do=%h want so=0 do=%h", i, net_so, net_do, w[3]); end
         end
      end
      idle();
   endtask

   task automatic test_polarity();
      idle();
      net_ro = 1; net_polarity = 0;
      nicEn = 1; nicWrEn = 1; addr = 2'd2;
      d_in = 64'h8000_0000_0000_0001; step();
      d_in = 64'h0000_0000_0000_0002; step();
      nicEn = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (net_so !== 0) begin errors++; $display("FAIL pol_blocked[%0d]: got so=%b want 0", i, net_so); end
      end
      net_polarity = 1; step();
      checks++; if (net_so !== 1 || net_do !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL pol_first: got so=%b do=%h want so=1 do=8000000000000001", net_so, net_do); end
      net_polarity = 0; step();
      checks++; if (net_so !== 1 || net_do !== 64'h0000_0000_0000_0002) begin errors++; $display("FAIL pol_second: got so=%b do=%h want so=1 do=2", net_so, net_do); end
      net_polarity = 1; step();
      checks++; if (net_so !== 0 || net_do !== 64'h0000_0000_0000_0002) begin errors++; $display("FAIL pol_hold: got so=%b do=%h want so=0 do=2", net_so, net_do); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] p[10];
      logic [DW-1:0] w[11];
      idle();
      // input side: prime to 2, then push and pop every cycle
      for (int i = 0; i < 10; i++) p[i] = rnd64();
      net_si = 1;
      net_di = p[0]; step();
      net_di = p[1]; step();
      nicEn = 1; nicWrEn = 0; addr = 2'd0;
      for (int i = 0; i < 8; i++) begin
         net_di = p[i + 2]; step();
         checks++; if (d_out !== p[i] || net_ri !== 1) begin errors++; $display("FAIL in_concurrent[%0d]: got d=%h ri=%b want d=%h ri=1", i, d_out, net_ri, p[i]); end
      end
      net_si = 0; addr = 2'd1; step();
      checks++; if (d_out !== 64'h8000_0000_0000_0002) begin errors++; $display("FAIL in_concurrent_count: got %h want 8000000000000002", d_out); end
      addr = 2'd0;
      for (int i = 8; i < 10; i++) begin
         step();
         checks++; if (d_out !== p[i]) begin errors++; $display("FAIL in_tail[%0d]: got %h want %h", i, d_out, p[i]); end
      end
      // output side: sustained write+send at count 2
      idle();
      for (int i = 0; i < 11; i++) begin w[i] = rnd64(); w[i][DW-1] = 1'b0; end
      nicEn = 1; nicWrEn = 1; addr = 2'd2;
      d_in = w[0]; step();
      d_in = w[1]; step();
      net_ro = 1;
      for (int i = 0; i < 6; i++) begin
         d_in = w[i + 2]; step();
         checks++; if (net_so !== 1 || net_do !== w[i]) begin errors++; $display("FAIL out_concurrent[%0d]: got so=%b do=%h want so=1 do=%h", i, net_so, net_do, w[i]); end
      end
      net_ro = 0; nicWrEn = 0; addr = 2'd3; step();
      checks++; if (d_out !== 64'h0000_0000_0000_0002) begin errors++; $display("FAIL out_concurrent_count: got %h want 2", d_out); end
      // at full: the send proceeds, the simultaneous write is rejected and flags overflow
      nicWrEn = 1; addr = 2'd2;
      d_in = w[8]; step();
      d_in = w[9]; step();
      net_ro = 1; d_in = w[10]; step();
      checks++; if (net_so !== 1 || net_do !== w[6]) begin errors++; $display("FAIL full_send: got so=%b do=%h want so=1 do=%h", net_so, net_do, w[6]); end
      net_ro = 0; nicWrEn = 0; addr = 2'd3; step();
      checks++; if (d_out !== 64'h4000_0000_0000_0003) begin errors++; $display("FAIL full_ovf_status: got %h want 4000000000000003", d_out); end
      nicEn = 0; net_ro = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i < 3) begin
            checks++; if (net_so !== 1 || net_do !== w[7 + i]) begin errors++; $display("FAIL full_drain[%0d]: got so=%b do=%h want so=1 do=%h", i, net_so, net_do, w[7 + i]); end
         end else begin
            checks++; if (net_so !== 0) begin errors++; $display("FAIL full_drain_end: got so=%b want 0", net_so); end
         end
      end
      idle();
   endtask

   task automatic test_random();
      bit exp_ri;
      for (int c = 0; c < 3000; c++) begin
         exp_ri       = (in_q.size() != ID);
         checks++; if (net_ri !== exp_ri) begin errors++; $display("FAIL rnd_net_ri@%0d: got %b want %b", c, net_ri, exp_ri); end
         nicEn        = ($urandom_range(0, 3) != 0);
         nicWrEn      = $urandom_range(0, 1);
         addr         = 2'($urandom_range(0, 3));
         d_in         = rnd64();
         net_si       = ($urandom_range(0, 2) != 0);
         net_di       = rnd64();
         net_ro       = ($urandom_range(0, 3) != 0);
         net_polarity = $urandom_range(0, 1);
         step();
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL rnd_d_out@%0d: got %h want %h", c, d_out, m_dout); end
         checks++; if (net_so !== m_so) begin errors++; $display("FAIL rnd_net_so@%0d: got %b want %b", c, net_so, m_so); end
         checks++; if (net_do !== m_do) begin errors++; $display("FAIL rnd_net_do@%0d: got %h want %h", c, net_do, m_do); end
      end
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      model_reset();
      step(); step();
      test_reset();
      test_in_fill();
      test_out_overflow();
      test_polarity();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
